// File: rtl/json_rx_pkg.sv
// Shared types and ASCII constants for the JSON motion command receiver.
// Holds FSM states, field order, error codes and small byte helpers.
package json_rx_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KQ1,
    S_KEY,
    S_KQ2,
    S_COLON,
    S_NSTART,
    S_NINT,
    S_NFRAC,
    S_NL
  } state_t;

  typedef enum logic [1:0] {
    F_T,
    F_L,
    F_R
  } field_t;

  typedef enum logic [2:0] {
    E_NONE   = 3'd0,
    E_SYNTAX = 3'd1,
    E_OVF    = 3'd2,
    E_LEN    = 3'd3,
    E_TMO    = 3'd4,
    E_RESYNC = 3'd5
  } err_t;

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic [7:0] key_char(input field_t f);
    logic [7:0] k;
    unique case (f)
      F_T:     k = 8'h54;
      F_L:     k = 8'h4C;
      default: k = 8'h52;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/json_cmd_rx_if.sv
// Byte-stream in / decoded command out bundle for json_cmd_rx.
// slave: decoder side (rx in, cmd/err out); master: the far side.
interface json_cmd_rx_if #(
  parameter int SPEED_W = 16
);
  import json_rx_pkg::*;

  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      cmd_valid;
  logic [7:0]                cmd_t;
  logic signed [SPEED_W-1:0] cmd_left;
  logic signed [SPEED_W-1:0] cmd_right;
  logic                      busy;
  logic                      err_valid;
  err_t                      err_code;

  modport slave (
    input  rx_data, rx_valid,
    output cmd_valid, cmd_t, cmd_left, cmd_right,
    output busy, err_valid, err_code
  );

  modport master (
    output rx_data, rx_valid,
    input  cmd_valid, cmd_t, cmd_left, cmd_right,
    input  busy, err_valid, err_code
  );

endinterface

// File: rtl/json_num_accum.sv
// Decimal number accumulator: mag*10+d per digit, sticky overflow.
// Ports: start/digit/d/dot/neg/raw in; nfrac, ovf, value, tval out.
module json_num_accum
  import json_rx_pkg::*;
#(
  parameter int SPEED_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      digit,
  input  logic [3:0]                d,
  input  logic                      dot,
  input  logic                      neg,
  input  logic                      raw,
  output logic [1:0]                nfrac,
  output logic                      ovf,
  output logic signed [SPEED_W-1:0] value,
  output logic [7:0]                tval
);
  localparam int AW = SPEED_W + 4;
  localparam int NW = AW + 4;
  localparam logic [63:0] MAXV =
    (64'd1 << (SPEED_W - 1)) - 64'd1;

  logic [AW-1:0]      mag;
  logic [NW-1:0]      nxt;
  logic [1:0]         nf_nxt;
  logic               frac_q;
  logic               neg_q;
  logic [63:0]        prod;
  logic [63:0]        lim;
  logic               too_big;
  logic [SPEED_W-1:0] mag_s;

  function automatic logic [9:0] pow10(
    input logic [1:0] nf
  );
    logic [9:0] p;
    unique case (nf)
      2'd0:    p = 10'd1000;
      2'd1:    p = 10'd100;
      2'd2:    p = 10'd10;
      default: p = 10'd1;
    endcase
    return p;
  endfunction

  function automatic logic [SPEED_W-1:0] scale(
    input logic [AW-1:0] m,
    input logic [1:0]    nf
  );
    return SPEED_W'(64'(m) * 64'(pow10(nf)));
  endfunction

  // Overflow is judged on the value the next digit would give once
  // scaled to thousandths, so mag itself never exceeds the limit.
  always_comb begin
    nxt     = NW'(mag) * NW'(10) + NW'(d);
    nf_nxt  = frac_q ? nfrac + 2'd1 : nfrac;
    prod    = raw ? 64'(nxt)
                  : 64'(nxt) * 64'(pow10(nf_nxt));
    lim     = raw ? 64'd255 : MAXV;
    too_big = prod > lim;
  end

  assign mag_s = scale(mag, nfrac);
  assign value = neg_q ? -mag_s : mag_s;
  assign tval  = mag[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag    <= '0;
      nfrac  <= '0;
      frac_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf    <= 1'b0;
    end else if (start) begin
      mag    <= '0;
      nfrac  <= '0;
      frac_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (neg) neg_q <= 1'b1;
      if (dot) frac_q <= 1'b1;
      if (digit) begin
        nfrac <= nf_nxt;
        if (ovf || too_big) ovf <= 1'b1;
        else mag <= nxt[AW-1:0];
      end
    end
  end

endmodule

// File: rtl/json_cmd_rx.sv
// Decodes {"T":t,"L":l,"R":r}\n frames from a UART byte stream.
// Ports: clk, rst, bus (slave: rx bytes in, cmd/err/busy out).
module json_cmd_rx
  import json_rx_pkg::*;
#(
  parameter int SPEED_W      = 16,
  parameter int MAX_LEN      = 48,
  parameter int TIMEOUT_CLKS = 50_000
) (
  input logic          clk,
  input logic          rst,
  json_cmd_rx_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  state_t                    state;
  state_t                    nstate;
  field_t                    field;
  logic [LW-1:0]             len;
  logic [TW-1:0]             tmo;
  logic                      sgn_q;
  logic [7:0]                t_q;
  logic signed [SPEED_W-1:0] l_q;
  logic signed [SPEED_W-1:0] r_q;
  logic                      cmd_valid_q;
  logic [7:0]                cmd_t_q;
  logic signed [SPEED_W-1:0] left_q;
  logic signed [SPEED_W-1:0] right_q;
  logic                      err_valid_q;
  err_t                      err_code_q;
  err_t                      perr;

  logic [7:0] c;
  logic       v;
  logic       dig;
  logic       skip;
  logic       is_term;
  logic       do_term;
  logic       commit;
  logic       acc_start;
  logic       acc_digit;
  logic       acc_dot;
  logic       acc_neg;

  logic [1:0]                nfrac;
  logic                      ovf;
  logic signed [SPEED_W-1:0] value;
  logic [7:0]                tval;

  assign c       = bus.rx_data;
  assign v       = bus.rx_valid;
  assign dig     = is_digit(c);
  assign skip    = (c == CH_SP) || (c == CH_CR);
  assign is_term = (field == F_R) ? (c == CH_RBRACE)
                                  : (c == CH_COMMA);

  assign acc_start = v && state == S_COLON
                       && c == CH_COLON;
  assign acc_neg   = v && state == S_NSTART
                       && c == CH_MINUS
                       && field != F_T && !sgn_q;
  assign acc_dot   = v && state == S_NINT
                       && c == CH_DOT && field != F_T;
  assign acc_digit = v && dig
                       && (state == S_NSTART
                           || state == S_NINT
                           || (state == S_NFRAC
                               && nfrac != 2'd3));

  json_num_accum #(
    .SPEED_W(SPEED_W)
  ) u_accum (
    .clk  (clk),
    .rst  (rst),
    .start(acc_start),
    .digit(acc_digit),
    .d    (c[3:0]),
    .dot  (acc_dot),
    .neg  (acc_neg),
    .raw  (field == F_T),
    .nfrac(nfrac),
    .ovf  (ovf),
    .value(value),
    .tval (tval)
  );

  // Next state for one in-frame byte other than '{'.
  always_comb begin
    nstate  = state;
    perr    = E_NONE;
    do_term = 1'b0;
    commit  = 1'b0;
    if (!skip) begin
      unique case (state)
        S_KQ1:
          if (c == CH_QUOTE) nstate = S_KEY;
          else perr = E_SYNTAX;
        S_KEY:
          if (c == key_char(field)) nstate = S_KQ2;
          else perr = E_SYNTAX;
        S_KQ2:
          if (c == CH_QUOTE) nstate = S_COLON;
          else perr = E_SYNTAX;
        S_COLON:
          if (c == CH_COLON) nstate = S_NSTART;
          else perr = E_SYNTAX;
        S_NSTART:
          if (dig) nstate = S_NINT;
          else if (acc_neg) nstate = S_NSTART;
          else perr = E_SYNTAX;
        S_NINT:
          if (dig) nstate = S_NINT;
          else if (acc_dot) nstate = S_NFRAC;
          else if (is_term) do_term = 1'b1;
          else perr = E_SYNTAX;
        S_NFRAC:
          if (dig && nfrac != 2'd3) nstate = S_NFRAC;
          else if (is_term && nfrac != 2'd0) do_term = 1'b1;
          else perr = E_SYNTAX;
        S_NL:
          if (c == CH_LF) begin
            commit = 1'b1;
            nstate = S_IDLE;
          end else begin
            perr = E_SYNTAX;
          end
        default: nstate = state;
      endcase
    end
    if (do_term) begin
      if (ovf) perr = E_OVF;
      else nstate = (field == F_R) ? S_NL : S_KQ1;
    end
    // The byte that fills the budget must be the closing '\n'.
    if (perr == E_NONE && !commit && len == LEN_LAST)
      perr = E_LEN;
    if (perr != E_NONE) nstate = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      field       <= F_T;
      len         <= '0;
      tmo         <= '0;
      sgn_q       <= 1'b0;
      t_q         <= '0;
      l_q         <= '0;
      r_q         <= '0;
      cmd_valid_q <= 1'b0;
      cmd_t_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= E_NONE;
    end else begin
      cmd_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      if (acc_start) sgn_q <= 1'b0;
      else if (acc_neg) sgn_q <= 1'b1;

      if (v || state == S_IDLE) begin
        tmo <= '0;
      end else if (tmo == TMO_LAST) begin
        err_valid_q <= 1'b1;
        err_code_q  <= E_TMO;
        state       <= S_IDLE;
      end else begin
        tmo <= tmo + 1'b1;
      end

      if (v) begin
        if (c == CH_LBRACE) begin
          // '{' always opens a frame, aborting any frame in flight.
          if (state != S_IDLE) begin
            err_valid_q <= 1'b1;
            err_code_q  <= E_RESYNC;
          end
          state <= S_KQ1;
          field <= F_T;
          len   <= LW'(1);
        end else if (state != S_IDLE) begin
          state <= nstate;
          len   <= len + 1'b1;
          if (perr != E_NONE) begin
            err_valid_q <= 1'b1;
            err_code_q  <= perr;
          end else begin
            if (do_term) begin
              unique case (field)
                F_T:     t_q <= tval;
                F_L:     l_q <= value;
                default: r_q <= value;
              endcase
              if (field != F_R)
                field <= field_t'(field + 2'd1);
            end
            if (commit) begin
              cmd_valid_q <= 1'b1;
              cmd_t_q     <= t_q;
              left_q      <= l_q;
              right_q     <= r_q;
            end
          end
        end
      end
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_t     = cmd_t_q;
  assign bus.cmd_left  = left_q;
  assign bus.cmd_right = right_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_json_cmd_rx.sv
// Directed bench for json_cmd_rx: frames, errors, timeout, reset.
// Drives bytes on negedge, counts cmd/err pulses on negedge.
module tb_json_cmd_rx;
  import json_rx_pkg::*;

  localparam int SPEED_W = 16;
  localparam int MAX_LEN = 48;
  localparam int TMO     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  json_cmd_rx_if #(.SPEED_W(SPEED_W)) bus ();

  json_cmd_rx #(
    .SPEED_W     (SPEED_W),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  int n_cmd  = 0;
  int n_err  = 0;
  int n_both = 0;
  int last_err = 0;
  int c0;
  int e0;
  string s;

  always @(negedge clk) begin
    if (bus.cmd_valid) n_cmd++;
    if (bus.err_valid) begin
      n_err++;
      last_err = int'(bus.err_code);
    end
    if (bus.cmd_valid && bus.err_valid) n_both++;
  end

  task automatic check(string tag, int got, int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(string str);
    for (int i = 0; i < str.len(); i++)
      send_byte(str[i]);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cmd(string tag, int t,
                           int l, int r);
    check({tag, ".t"}, int'(bus.cmd_t), t);
    check({tag, ".l"}, int'(bus.cmd_left), l);
    check({tag, ".r"}, int'(bus.cmd_right), r);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.cmd_valid", int'(bus.cmd_valid), 0);
    check("rst.err_valid", int'(bus.err_valid), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.err_code", int'(bus.err_code), 0);
    check_cmd("rst", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
    settle();
    check("f1.ncmd", n_cmd, 1);
    check("f1.nerr", n_err, 0);
    check_cmd("f1", 1, 500, 500);

    send_str("{\"T\":1,\"L\":-0.25,\"R\":0.25}\n");
    settle();
    check("f2.ncmd", n_cmd, 2);
    check_cmd("f2", 1, -250, 250);
    send_str("{\"T\":1,\"L\":0.25,\"R\":-0.25}\n");
    settle();
    check("f3.ncmd", n_cmd, 3);
    check_cmd("f3", 1, 250, -250);

    send_str("{\"T\":1,\"L\":0.5X");
    settle();
    check("syn.nerr", n_err, 1);
    check("syn.code", last_err, 1);
    check("syn.busy", int'(bus.busy), 0);
    check("syn.held", int'(bus.err_code), 1);
    send_str("{\"T\":7,\"L\":1.25,\"R\":-3}\n");
    settle();
    check("f4.ncmd", n_cmd, 4);
    check_cmd("f4", 7, 1250, -3000);

    send_str("{\"T\":1,\"L\":40.0,\"R\":0}\n");
    settle();
    check("ovf.nerr", n_err, 2);
    check("ovf.code", last_err, 2);
    check("ovf.ncmd", n_cmd, 4);
    check_cmd("ovf", 7, 1250, -3000);

    send_str("{\"T\":256,\"L\":0,\"R\":0}\n");
    settle();
    check("tovf.nerr", n_err, 3);
    check("tovf.code", last_err, 2);

    send_str("{\"T\":255,\"L\":32.767,\"R\":-0}\n");
    settle();
    check("max.ncmd", n_cmd, 5);
    check_cmd("max", 255, 32767, 0);
    send_str("{\"T\":0,\"L\":-32.767,\"R\": 1.5 }\r\n");
    settle();
    check("min.ncmd", n_cmd, 6);
    check_cmd("min", 0, -32767, 1500);

    send_str("{\"T\":1,\"L\":0.1234");
    settle();
    check("frac4.nerr", n_err, 4);
    check("frac4.code", last_err, 1);
    send_str("{\"T\":1,\"L\":1.,");
    settle();
    check("dot.nerr", n_err, 5);
    check("dot.code", last_err, 1);
    send_str("{\"T\":-1,");
    settle();
    check("tneg.nerr", n_err, 6);
    check("tneg.code", last_err, 1);

    send_str("{\"T\":4,\"L\":");
    repeat (TMO - 2) @(negedge clk);
    send_str("0.5,\"R\":0.5}\n");
    settle();
    check("tmoedge.nerr", n_err, 6);
    check("tmoedge.ncmd", n_cmd, 7);
    check_cmd("tmoedge", 4, 500, 500);

    send_str("{\"T\":1,\"L\":0.5");
    check("tmo.busy", int'(bus.busy), 1);
    repeat (TMO - 10) @(negedge clk);
    check("tmo.early", n_err, 6);
    repeat (20) @(negedge clk);
    check("tmo.nerr", n_err, 7);
    check("tmo.code", last_err, 4);
    check("tmo.idle", int'(bus.busy), 0);

    send_str("{\"T\":1,\"L\":");
    send_str("{\"T\":2,\"L\":-1,\"R\":2.5}\n");
    settle();
    check("rsy.nerr", n_err, 8);
    check("rsy.code", last_err, 5);
    check("rsy.ncmd", n_cmd, 8);
    check_cmd("rsy", 2, -1000, 2500);

    s = "{\"T\":9,\"L\":0.5,\"R\":0.5}";
    while (s.len() < MAX_LEN - 1) s = {s, " "};
    send_str({s, "\n"});
    settle();
    check("len48.ncmd", n_cmd, 9);
    check("len48.nerr", n_err, 8);
    check_cmd("len48", 9, 500, 500);
    send_str({s, " \n"});
    settle();
    check("len49.nerr", n_err, 9);
    check("len49.code", last_err, 3);
    check("len49.ncmd", n_cmd, 9);

    send_str("{\"T\":1,\"L\":0.5");
    c0 = n_cmd;
    e0 = n_err;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cmd("mrst", 0, 0, 0);
    check("mrst.busy", int'(bus.busy), 0);
    check("mrst.code", int'(bus.err_code), 0);
    rst = 1'b0;
    settle();
    check("mrst.ncmd", n_cmd, c0);
    check("mrst.nerr", n_err, e0);
    send_str("{\"T\":3,\"L\":0.001,\"R\":-0.1}\n");
    settle();
    check("post.ncmd", n_cmd, c0 + 1);
    check_cmd("post", 3, 1, -100);

    check("both.pulse", n_both, 0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
